if_stage: RTL and testbench

Fetch stage feeding DC_stage. Generates fetch PCs and issues in-order requests to instruction memory. Buffers responses in a small fetch queue, predecodes JAL for a static taken redirect, and presents {pc, inst, jump} to decode with a valid/ready handshake. Handles back-end redirects (mispredict) by flushing the queue and discarding wrong-path responses still in flight.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 77 +++++++
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and helpers.
//   fq_entry_t : one fetch-queue entry {pc, inst, jump}
//   OPC_JAL    : major opcode (inst[6:2]) of JAL
//   j_imm      : sign-extended J-type immediate from inst[31:12]
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OPC_JAL = 5'b11011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            jump;
  } fq_entry_t;

  // hi is inst[31:12]; result is {imm[20:1], 1'b0} sign-extended to XLEN
  function automatic logic [XLEN-1:0] j_imm(input logic [19:0] hi);
    return {{12{hi[19]}}, hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries with registered head outputs.
//   clk, rst         : clock, async active-high reset
//   enq, enq_data    : push one entry
//   deq              : pop the head (ignored when empty)
//   flush            : clear the queue, wins over enq/deq
//   count            : current occupancy
//   head_valid, head : registered head of the queue
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq,
  input  fq_entry_t              enq_data,
  input  logic                   deq,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output fq_entry_t              head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [PTR_W-1:0] wr_next;
  logic [CNT_W-1:0] count_next;
  logic             do_enq;
  logic             do_deq;

  // Next pointers/count; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    do_enq     = enq && !flush;
    do_deq     = deq && !flush && (count != '0);
    rd_next    = rd_ptr + PTR_W'(do_deq);
    wr_next    = wr_ptr + PTR_W'(do_enq);
    count_next = count + CNT_W'(do_enq) - CNT_W'(do_deq);
    if (flush) begin
      rd_next    = '0;
      wr_next    = '0;
      count_next = '0;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_data;
    end
  end

  // Control state and registered head; an entry written into the slot that
  // becomes the head this cycle is forwarded from enq_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_next;
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (!flush) begin
        head <= (do_enq && (wr_ptr == rd_next)) ? enq_data : mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, credit-based in-order memory
// requests, JAL predecode with static taken redirect, wrong-path response
// dropping and a fetch queue feeding decode.
//   clk, rst                     : clock, async active-high reset
//   im_req_valid/addr/ready      : instruction memory request
//   im_resp_valid/inst           : in-order, never-stalled responses
//   mispredict, redirect_pc      : back-end redirect
//   stall, DC_ready              : decode hold / accept
//   IF_valid, DC_in_pc/inst/jump : queue head presented to decode
module if_stage
  import fetch_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req_valid,
  output logic [31:0] im_req_addr,
  input  logic        im_req_ready,
  input  logic        im_resp_valid,
  input  logic [31:0] im_resp_inst,
  input  logic        mispredict,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        DC_ready,
  output logic        IF_valid,
  output logic [31:0] DC_in_pc,
  output logic [31:0] DC_in_inst,
  output logic        DC_in_jump
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      fetch_pc_next;
  logic [31:0]      resp_pc_next;
  logic [31:0]      jal_target;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] out_next;
  logic [CNT_W-1:0] drop_next;
  logic [CNT_W-1:0] fq_count;
  logic [SUM_W-1:0] credit_used;
  logic             req_fire;
  logic             resp_keep;
  logic             resp_jump;
  logic             jal_taken;
  logic             deq;
  logic             head_valid;
  fq_entry_t        enq_data;
  fq_entry_t        head;

  // Credit, predecode and next-state for the PC/counter registers
  always_comb begin
    credit_used  = SUM_W'(outstanding) + SUM_W'(fq_count);
    // Every in-flight response has a reserved queue slot
    im_req_valid = (credit_used < SUM_W'(FQ_DEPTH)) && !mispredict;
    req_fire     = im_req_valid && im_req_ready;
    out_next     = outstanding + CNT_W'(req_fire) - CNT_W'(im_resp_valid);
    resp_jump    = (im_resp_inst[6:2] == OPC_JAL);
    resp_keep    = im_resp_valid && (drop_cnt == '0) && !mispredict;
    jal_taken    = resp_keep && resp_jump;
    jal_target   = resp_pc + j_imm(im_resp_inst[31:12]);
    enq_data     = '{pc: resp_pc, inst: im_resp_inst, jump: resp_jump};
    deq          = head_valid && DC_ready && !stall;

    fetch_pc_next = req_fire ? (fetch_pc + 32'd4) : fetch_pc;
    resp_pc_next  = resp_keep ? (resp_pc + 32'd4) : resp_pc;
    drop_next     = (im_resp_valid && (drop_cnt != '0)) ? (drop_cnt - CNT_W'(1)) : drop_cnt;

    // Any redirect turns every still-outstanding request into wrong path
    if (mispredict) begin
      fetch_pc_next = redirect_pc;
      resp_pc_next  = redirect_pc;
      drop_next     = out_next;
    end else if (jal_taken) begin
      fetch_pc_next = jal_target;
      resp_pc_next  = jal_target;
      drop_next     = out_next;
    end
  end

  // PC and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      fetch_pc    <= fetch_pc_next;
      resp_pc     <= resp_pc_next;
      outstanding <= out_next;
      drop_cnt    <= drop_next;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk        (clk),
    .rst        (rst),
    .enq        (resp_keep),
    .enq_data   (enq_data),
    .deq        (deq),
    .flush      (mispredict),
    .count      (fq_count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign im_req_addr = fetch_pc;
  assign IF_valid    = head_valid;
  assign DC_in_pc    = head.pc;
  assign DC_in_inst  = head.inst;
  assign DC_in_jump  = head.jump;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: JAL predecode vector table plus
// directed sequences for stall, mispredict, JAL+mispredict and reset.
module tb_if_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req_valid;
  logic [31:0] im_req_addr;
  logic        im_req_ready;
  logic        im_resp_valid;
  logic [31:0] im_resp_inst;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        DC_ready;
  logic        IF_valid;
  logic [31:0] DC_in_pc;
  logic [31:0] DC_in_inst;
  logic        DC_in_jump;

  always #5 clk = ~clk;

  if_stage #(.FQ_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .im_req_valid(im_req_valid), .im_req_addr(im_req_addr), .im_req_ready(im_req_ready),
    .im_resp_valid(im_resp_valid), .im_resp_inst(im_resp_inst),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stall(stall), .DC_ready(DC_ready),
    .IF_valid(IF_valid), .DC_in_pc(DC_in_pc), .DC_in_inst(DC_in_inst), .DC_in_jump(DC_in_jump)
  );

  // Memory model: fixed latency of 1 or 2 cycles, in order
  int          mem_lat;
  logic [31:0] jal_addr;
  logic [31:0] jal_word;
  logic        v1, v2;
  logic [31:0] i1, i2;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    if (a == jal_addr) return jal_word;
    return (a << 8) | 32'h0000_0013;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; i1 <= '0; i2 <= '0;
    end else begin
      v1 <= im_req_valid && im_req_ready;
      i1 <= inst_at(im_req_addr);
      v2 <= v1;
      i2 <= i1;
    end
  end
  assign im_resp_valid = (mem_lat == 1) ? v1 : v2;
  assign im_resp_inst  = (mem_lat == 1) ? i1 : i2;

  // Decode-side monitor and request counter, sampled mid-cycle
  fq_entry_t dec_q[$];
  int        req_total = 0;
  always @(negedge clk) begin
    if (!rst && IF_valid && DC_ready && !stall) dec_q.push_back({DC_in_pc, DC_in_inst, DC_in_jump});
    if (!rst && im_req_valid && im_req_ready) req_total++;
  end

  int n_vec = 0;
  int n_bad = 0;
  int dec_base = 0;
  int req_base = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic fq_entry_t dq(input int i);
    if (dec_base + i < dec_q.size()) return dec_q[dec_base + i];
    return '0;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic ready);
    step(1);
    rst = 1'b1; mispredict = 1'b0; stall = 1'b0; DC_ready = ready; mem_lat = lat;
    step(2);
    rst = 1'b0;
    dec_base = dec_q.size();
    req_base = req_total;
  endtask

  task automatic wait_dec(input string name, input int n, input int budget);
    int c = 0;
    while ((dec_q.size() - dec_base) < n && c < budget) begin
      step(1);
      c++;
    end
    check(name, 32'((dec_q.size() - dec_base) >= n), 32'd1);
  endtask

  typedef struct {
    logic [31:0] inst;
    logic        jump;
    logic [31:0] next_pc;
  } vec_t;
  vec_t vecs[8];

  initial begin #300000; $display("FAIL watchdog: simulation time limit"); $fatal(1); end

  initial begin
    int k;
    int split;
    logic seen;

    vecs[0] = '{32'h0800_006F, 1'b1, 32'h0000_0090};  // jal x0, +0x80
    vecs[1] = '{32'h0000_0013, 1'b0, 32'h0000_0014};  // addi
    vecs[2] = '{32'hFF1F_F06F, 1'b1, 32'h0000_0000};  // jal x0, -16
    vecs[3] = '{32'h0010_006F, 1'b1, 32'h0000_0810};  // jal x0, +0x800
    vecs[4] = '{32'h0000_106F, 1'b1, 32'h0000_1010};  // jal x0, +0x1000
    vecs[5] = '{32'h0080_006F, 1'b1, 32'h0000_0018};  // jal x0, +8
    vecs[6] = '{32'h0800_00EF, 1'b1, 32'h0000_0090};  // jal x1, +0x80
    vecs[7] = '{32'h0000_8067, 1'b0, 32'h0000_0014};  // jalr, not predecoded

    rst = 1'b1; mem_lat = 1; DC_ready = 1'b1; stall = 1'b0; mispredict = 1'b0;
    redirect_pc = '0; im_req_ready = 1'b1; jal_addr = 32'hFFFF_FFFF; jal_word = '0;

    // Reset values and first requests
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.IF_valid", 32'(IF_valid), 32'd0);
    check("rst.DC_in_pc", DC_in_pc, 32'd0);
    check("rst.DC_in_inst", DC_in_inst, 32'd0);
    check("rst.DC_in_jump", 32'(DC_in_jump), 32'd0);
    check("rst.im_req_addr", im_req_addr, 32'd0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("c0.im_req_valid", 32'(im_req_valid), 32'd1);
    check("c0.im_req_addr", im_req_addr, 32'h0);
    @(negedge clk);
    check("c1.im_req_addr", im_req_addr, 32'h4);
    check("c1.IF_valid", 32'(IF_valid), 32'd0);
    @(negedge clk);
    check("c2.im_req_addr", im_req_addr, 32'h8);
    check("c2.IF_valid", 32'(IF_valid), 32'd1);
    check("c2.DC_in_pc", DC_in_pc, 32'h0);
    check("c2.DC_in_inst", DC_in_inst, 32'h13);

    // Predecode table: word under test sits at pc 0x10
    for (int i = 0; i < 8; i++) begin
      jal_addr = 32'h10;
      jal_word = vecs[i].inst;
      do_reset(1, 1'b1);
      wait_dec($sformatf("vec%0d.wait", i), 6, 60);
      k = -1;
      for (int j = 0; j < dec_q.size() - dec_base; j++)
        if (k < 0 && dq(j).pc == 32'h10) k = j;
      check($sformatf("vec%0d.index", i), 32'(k), 32'd4);
      if (k < 0) k = 4;
      check($sformatf("vec%0d.inst", i), dq(k).inst, vecs[i].inst);
      check($sformatf("vec%0d.jump", i), 32'(dq(k).jump), 32'(vecs[i].jump));
      check($sformatf("vec%0d.next_pc", i), dq(k + 1).pc, vecs[i].next_pc);
    end
    jal_addr = 32'hFFFF_FFFF;

    // Decode blocked: queue fills to 4, stall holds the head, drain in order
    do_reset(1, 1'b0);
    step(10);
    @(negedge clk);
    check("full.req_count", 32'(req_total - req_base), 32'd4);
    check("full.im_req_valid", 32'(im_req_valid), 32'd0);
    check("full.IF_valid", 32'(IF_valid), 32'd1);
    step(1);
    DC_ready = 1'b1; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d.DC_in_pc", c), DC_in_pc, 32'h0);
      step(1);
    end
    check("stall.no_deq", 32'(dec_q.size() - dec_base), 32'd0);
    stall = 1'b0;
    @(negedge clk);
    check("credit.same_cycle", 32'(im_req_valid), 32'd0);
    @(negedge clk);
    check("credit.next_cycle", 32'(im_req_valid), 32'd1);
    wait_dec("drain.wait", 12, 100);
    for (int j = 0; j < 12; j++)
      check($sformatf("drain%0d.pc", j), dq(j).pc, 32'(4 * j));

    // Mispredict with two requests outstanding (2-cycle memory)
    do_reset(2, 1'b1);
    step(8);
    mispredict = 1'b1; redirect_pc = 32'h100; DC_ready = 1'b0;
    split = dec_q.size() - dec_base;
    @(negedge clk);
    check("mp.im_req_valid", 32'(im_req_valid), 32'd0);
    step(1);
    mispredict = 1'b0; DC_ready = 1'b1;
    @(negedge clk);
    check("mp1.IF_valid", 32'(IF_valid), 32'd0);
    check("mp1.im_req_valid", 32'(im_req_valid), 32'd1);
    check("mp1.im_req_addr", im_req_addr, 32'h100);
    @(negedge clk);
    check("mp2.IF_valid", 32'(IF_valid), 32'd0);
    step(1);
    wait_dec("mp.wait", split + 2, 40);
    check("mp.before_last_pc", dq(split - 1).pc, 32'(4 * (split - 1)));
    check("mp.first_pc", dq(split).pc, 32'h100);
    check("mp.first_inst", dq(split).inst, 32'h0001_0013);
    check("mp.second_pc", dq(split + 1).pc, 32'h104);

    // JAL response and mispredict in the same cycle
    jal_addr = 32'h10; jal_word = 32'h0800_006F;
    do_reset(1, 1'b1);
    k = 0;
    while (!(im_resp_valid && im_resp_inst == jal_word) && k < 40) begin
      step(1);
      k++;
    end
    check("jmp.found", 32'(k < 40), 32'd1);
    mispredict = 1'b1; redirect_pc = 32'h200; DC_ready = 1'b0;
    split = dec_q.size() - dec_base;
    step(1);
    mispredict = 1'b0; DC_ready = 1'b1;
    @(negedge clk);
    check("jmp.im_req_addr", im_req_addr, 32'h200);
    check("jmp.IF_valid", 32'(IF_valid), 32'd0);
    step(1);
    wait_dec("jmp.wait", split + 1, 40);
    check("jmp.next_pc", dq(split).pc, 32'h200);
    check("jmp.next_jump", 32'(dq(split).jump), 32'd0);
    seen = 1'b0;
    for (int j = 0; j < dec_q.size() - dec_base; j++)
      if (dq(j).pc == 32'h10) seen = 1'b1;
    check("jmp.not_enqueued", 32'(seen), 32'd0);
    jal_addr = 32'hFFFF_FFFF;

    // Asynchronous reset while the queue is full
    do_reset(1, 1'b0);
    step(8);
    @(negedge clk);
    check("arst.before", 32'(IF_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst.IF_valid", 32'(IF_valid), 32'd0);
    check("arst.DC_in_pc", DC_in_pc, 32'h0);
    check("arst.im_req_addr", im_req_addr, 32'h0);
    step(1);
    rst = 1'b0; DC_ready = 1'b1;
    dec_base = dec_q.size();
    @(negedge clk);
    check("arst.restart_valid", 32'(im_req_valid), 32'd1);
    check("arst.restart_addr", im_req_addr, 32'h0);
    step(1);
    wait_dec("arst.wait", 2, 20);
    check("arst.pc0", dq(0).pc, 32'h0);
    check("arst.pc1", dq(1).pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
